// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control FSM
// Optional CTRL_PERF_EN adds InstrCount/StallCount performance counters.
module multicycle_control #(
  parameter int OPW      = 3,
  parameter int WAIT_MAX = 0
) (
  input  logic           CLK,
  input  logic           Reset_n,
  input  logic           Start,
  input  logic           Halt,
  input  logic [OPW-1:0] Opcode,
  input  logic           FetchAck,
  input  logic           MemAck,
  output logic           FetchReq,
  output logic           InstrLoad,
  output logic           Branch,
  output logic           Load,
  output logic           Shift,
  output logic           ReadMem,
  output logic           WriteMem,
  output logic           Copy,
  output logic           WriteReg,
  output logic [1:0]     ALUOp,
  output logic           PCEn,
  output logic           Done,
  output logic           Illegal,
  output logic           Timeout
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0]    InstrCount,
  output logic [31:0]    StallCount
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_t;

  localparam logic [2:0] OP_SB  = 3'd0;
  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_CPY = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SL  = 3'd6;
  localparam logic [2:0] OP_BNE = 3'd7;

  // Counter holds 0..WAIT_MAX-1; the WAIT_MAX-th unacked cycle is the timeout cycle.
  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] WAIT_LIM = CW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  state_t        state, state_next;
  logic [2:0]    op_q;
  logic          halt_pend;
  logic [CW-1:0] wait_cnt;
  logic          opcode_illegal;
  logic          waiting;
  logic          timeout_hit;
  logic          in_op;
  state_t        boundary;

  generate
    if (OPW > 3) begin : g_wide_op
      assign opcode_illegal = |Opcode[OPW-1:3];
    end else begin : g_narrow_op
      assign opcode_illegal = 1'b0;
    end
  endgenerate

  assign waiting     = ((state == S_FETCH) && !FetchAck) || ((state == S_MEM) && !MemAck);
  assign timeout_hit = (WAIT_MAX > 0) && waiting && (wait_cnt == WAIT_LIM);
  assign in_op       = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);
  // A Halt seen in the last cycle of an instruction stops at this same boundary.
  assign boundary    = (halt_pend || Halt) ? S_HALTED : S_FETCH;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    FetchReq   = 1'b0;
    InstrLoad  = 1'b0;
    Branch     = 1'b0;
    Load       = 1'b0;
    Shift      = 1'b0;
    ReadMem    = 1'b0;
    WriteMem   = 1'b0;
    Copy       = 1'b0;
    WriteReg   = 1'b0;
    ALUOp      = 2'b00;
    PCEn       = 1'b0;
    Done       = 1'b0;

    if (in_op) begin
      Load  = (op_q == OP_LB);
      Shift = (op_q == OP_SL);
      Copy  = (op_q == OP_CPY);
      case (op_q)
        OP_ADD:  ALUOp = 2'b01;
        OP_XOR:  ALUOp = 2'b10;
        OP_BNE:  ALUOp = 2'b11;
        default: ALUOp = 2'b00;
      endcase
    end

    case (state)
      S_IDLE: begin
        if (Start) state_next = S_FETCH;
      end
      S_FETCH: begin
        FetchReq = 1'b1;
        if (FetchAck) begin
          InstrLoad  = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_HALTED;
        end
      end
      S_DECODE: begin
        state_next = opcode_illegal ? S_HALTED : S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_BNE) begin
          Branch     = 1'b1;
          PCEn       = 1'b1;
          state_next = boundary;
        end else if ((op_q == OP_SB) || (op_q == OP_LB)) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        ReadMem  = (op_q == OP_LB);
        WriteMem = (op_q == OP_SB);
        if (MemAck) begin
          if (op_q == OP_LB) begin
            state_next = S_WB;
          end else begin
            PCEn       = 1'b1;
            state_next = boundary;
          end
        end else if (timeout_hit) begin
          state_next = S_HALTED;
        end
      end
      S_WB: begin
        WriteReg   = 1'b1;
        PCEn       = 1'b1;
        state_next = boundary;
      end
      S_HALTED: begin
        Done = 1'b1;
        if (Start) state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      op_q      <= 3'd0;
      halt_pend <= 1'b0;
      wait_cnt  <= '0;
      Illegal   <= 1'b0;
      Timeout   <= 1'b0;
    end else begin
      if (state == S_DECODE) op_q <= Opcode[2:0];

      if ((state == S_HALTED) && Start) begin
        halt_pend <= 1'b0;
        Illegal   <= 1'b0;
        Timeout   <= 1'b0;
      end else begin
        if (Halt && (state != S_IDLE) && (state != S_HALTED)) halt_pend <= 1'b1;
        if ((state == S_DECODE) && opcode_illegal) Illegal <= 1'b1;
        if (timeout_hit) Timeout <= 1'b1;
      end

      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (waiting && (WAIT_MAX > 0)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

`ifdef CTRL_PERF_EN
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      InstrCount <= 32'd0;
      StallCount <= 32'd0;
    end else if ((state == S_HALTED) && Start) begin
      InstrCount <= 32'd0;
      StallCount <= 32'd0;
    end else begin
      if (PCEn)    InstrCount <= InstrCount + 32'd1;
      if (waiting) StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
// Three instances: default, OPW=4 (illegal opcodes), WAIT_MAX=5 (timeout).
module tb_multicycle_control;

  localparam logic [14:0] FREQ = 15'h0001;
  localparam logic [14:0] ILD  = 15'h0002;
  localparam logic [14:0] BR   = 15'h0004;
  localparam logic [14:0] LD   = 15'h0008;
  localparam logic [14:0] SH   = 15'h0010;
  localparam logic [14:0] RM   = 15'h0020;
  localparam logic [14:0] WM   = 15'h0040;
  localparam logic [14:0] CP   = 15'h0080;
  localparam logic [14:0] WR   = 15'h0100;
  localparam logic [14:0] PC   = 15'h0200;
  localparam logic [14:0] DN   = 15'h0400;
  localparam logic [14:0] IL   = 15'h0800;
  localparam logic [14:0] TO   = 15'h1000;
  localparam logic [14:0] A1   = 15'h2000;
  localparam logic [14:0] A2   = 15'h4000;
  localparam logic [14:0] A3   = 15'h6000;

  logic       CLK;
  logic       Reset_n;
  logic       Start, Halt, FetchAck, MemAck;
  logic [3:0] op4;
  wire [14:0] ob0, ob1, ob2;
`ifdef CTRL_PERF_EN
  wire [31:0] ic0, sc0, ic1, sc1, ic2, sc2;
`endif

  int checks = 0;
  int fails  = 0;
  logic [22:0] tbl [32];
  int n;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  multicycle_control #(.OPW(3), .WAIT_MAX(0)) u_dut0 (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Halt(Halt), .Opcode(op4[2:0]),
    .FetchAck(FetchAck), .MemAck(MemAck),
    .FetchReq(ob0[0]), .InstrLoad(ob0[1]), .Branch(ob0[2]), .Load(ob0[3]), .Shift(ob0[4]),
    .ReadMem(ob0[5]), .WriteMem(ob0[6]), .Copy(ob0[7]), .WriteReg(ob0[8]), .PCEn(ob0[9]),
    .Done(ob0[10]), .Illegal(ob0[11]), .Timeout(ob0[12]), .ALUOp(ob0[14:13])
`ifdef CTRL_PERF_EN
    , .InstrCount(ic0), .StallCount(sc0)
`endif
  );

  multicycle_control #(.OPW(4), .WAIT_MAX(0)) u_dut1 (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Halt(Halt), .Opcode(op4),
    .FetchAck(FetchAck), .MemAck(MemAck),
    .FetchReq(ob1[0]), .InstrLoad(ob1[1]), .Branch(ob1[2]), .Load(ob1[3]), .Shift(ob1[4]),
    .ReadMem(ob1[5]), .WriteMem(ob1[6]), .Copy(ob1[7]), .WriteReg(ob1[8]), .PCEn(ob1[9]),
    .Done(ob1[10]), .Illegal(ob1[11]), .Timeout(ob1[12]), .ALUOp(ob1[14:13])
`ifdef CTRL_PERF_EN
    , .InstrCount(ic1), .StallCount(sc1)
`endif
  );

  multicycle_control #(.OPW(3), .WAIT_MAX(5)) u_dut2 (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Halt(Halt), .Opcode(op4[2:0]),
    .FetchAck(FetchAck), .MemAck(MemAck),
    .FetchReq(ob2[0]), .InstrLoad(ob2[1]), .Branch(ob2[2]), .Load(ob2[3]), .Shift(ob2[4]),
    .ReadMem(ob2[5]), .WriteMem(ob2[6]), .Copy(ob2[7]), .WriteReg(ob2[8]), .PCEn(ob2[9]),
    .Done(ob2[10]), .Illegal(ob2[11]), .Timeout(ob2[12]), .ALUOp(ob2[14:13])
`ifdef CTRL_PERF_EN
    , .InstrCount(ic2), .StallCount(sc2)
`endif
  );

  function automatic logic [22:0] row(input logic st, input logic hl, input logic fa,
                                      input logic ma, input logic [3:0] op, input logic [14:0] ex);
    return {st, hl, fa, ma, op, ex};
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    {Start, Halt, FetchAck, MemAck, op4} = '0;
    Reset_n = 1'b0;
    @(negedge CLK);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b1;
    {Halt, FetchAck, MemAck, op4} = '0;
    Start = 1'b1;
    #2 Reset_n = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (ob0 !== 15'h0) begin fails++; $display("FAIL reset dut0: got %h want %h", ob0, 15'h0); end
    checks++;
    if (ob1 !== 15'h0) begin fails++; $display("FAIL reset dut1: got %h want %h", ob1, 15'h0); end
    checks++;
    if (ob2 !== 15'h0) begin fails++; $display("FAIL reset dut2: got %h want %h", ob2, 15'h0); end
    Start = 1'b0;
    Reset_n = 1'b1;
  endtask

  task automatic test_alu_ops();
    do_reset();
    tbl[0]  = row(1, 0, 1, 0, 4'h2, 15'h0);
    tbl[1]  = row(0, 0, 1, 0, 4'h2, FREQ | ILD);
    tbl[2]  = row(0, 0, 1, 0, 4'h2, 15'h0);
    tbl[3]  = row(0, 0, 1, 0, 4'h2, A1);
    tbl[4]  = row(0, 0, 1, 0, 4'h2, A1 | WR | PC);
    tbl[5]  = row(0, 0, 1, 0, 4'h6, FREQ | ILD);
    tbl[6]  = row(0, 0, 1, 0, 4'h6, 15'h0);
    tbl[7]  = row(0, 0, 1, 0, 4'h6, SH);
    tbl[8]  = row(0, 0, 1, 0, 4'h6, SH | WR | PC);
    tbl[9]  = row(0, 0, 1, 0, 4'h5, FREQ | ILD);
    tbl[10] = row(0, 0, 1, 0, 4'h5, 15'h0);
    tbl[11] = row(0, 0, 1, 0, 4'h5, CP);
    tbl[12] = row(0, 0, 1, 0, 4'h5, CP | WR | PC);
    tbl[13] = row(0, 0, 1, 0, 4'h4, FREQ | ILD);
    tbl[14] = row(0, 0, 1, 0, 4'h4, 15'h0);
    tbl[15] = row(0, 0, 1, 0, 4'h4, A2);
    tbl[16] = row(0, 0, 1, 0, 4'h4, A2 | WR | PC);
    tbl[17] = row(0, 0, 1, 0, 4'h3, FREQ | ILD);
    tbl[18] = row(0, 0, 1, 0, 4'h3, 15'h0);
    tbl[19] = row(0, 0, 1, 0, 4'h3, 15'h0);
    tbl[20] = row(0, 0, 1, 0, 4'h3, WR | PC);
    n = 21;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      {Start, Halt, FetchAck, MemAck, op4} = tbl[i][22:15];
      #1;
      checks++;
      if (ob0 !== tbl[i][14:0]) begin
        fails++; $display("FAIL alu_ops step %0d: got %h want %h", i, ob0, tbl[i][14:0]);
      end
    end
  endtask

  task automatic test_load();
    do_reset();
    tbl[0] = row(1, 0, 1, 0, 4'h1, 15'h0);
    tbl[1] = row(0, 0, 1, 0, 4'h1, FREQ | ILD);
    tbl[2] = row(0, 0, 1, 0, 4'h1, 15'h0);
    tbl[3] = row(0, 0, 1, 0, 4'h1, LD);
    tbl[4] = row(0, 0, 0, 0, 4'h1, LD | RM);
    tbl[5] = row(0, 0, 0, 0, 4'h1, LD | RM);
    tbl[6] = row(0, 0, 0, 0, 4'h1, LD | RM);
    tbl[7] = row(0, 0, 0, 1, 4'h1, LD | RM);
    tbl[8] = row(0, 0, 0, 0, 4'h1, LD | WR | PC);
    tbl[9] = row(0, 0, 0, 0, 4'h1, FREQ);
    n = 10;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      {Start, Halt, FetchAck, MemAck, op4} = tbl[i][22:15];
      #1;
      checks++;
      if (ob0 !== tbl[i][14:0]) begin
        fails++; $display("FAIL load step %0d: got %h want %h", i, ob0, tbl[i][14:0]);
      end
    end
  endtask

  task automatic test_branch_store();
    do_reset();
    tbl[0]  = row(1, 0, 1, 0, 4'h7, 15'h0);
    tbl[1]  = row(0, 0, 1, 0, 4'h7, FREQ | ILD);
    tbl[2]  = row(0, 0, 1, 0, 4'h7, 15'h0);
    tbl[3]  = row(0, 0, 1, 0, 4'h7, BR | PC | A3);
    tbl[4]  = row(0, 0, 1, 0, 4'h0, FREQ | ILD);
    tbl[5]  = row(0, 0, 1, 0, 4'h0, 15'h0);
    tbl[6]  = row(0, 0, 0, 0, 4'h0, 15'h0);
    tbl[7]  = row(0, 0, 0, 0, 4'h0, WM);
    tbl[8]  = row(0, 0, 0, 1, 4'h0, WM | PC);
    tbl[9]  = row(0, 0, 0, 0, 4'h0, FREQ);
    tbl[10] = row(0, 0, 0, 0, 4'h0, FREQ);
    n = 11;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      {Start, Halt, FetchAck, MemAck, op4} = tbl[i][22:15];
      #1;
      checks++;
      if (ob0 !== tbl[i][14:0]) begin
        fails++; $display("FAIL branch_store step %0d: got %h want %h", i, ob0, tbl[i][14:0]);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    tbl[0]  = row(1, 0, 1, 0, 4'h2, 15'h0);
    tbl[1]  = row(0, 0, 1, 0, 4'h2, FREQ | ILD);
    tbl[2]  = row(0, 0, 1, 0, 4'h2, 15'h0);
    tbl[3]  = row(0, 1, 1, 0, 4'h2, A1);
    tbl[4]  = row(0, 0, 1, 0, 4'h2, A1 | WR | PC);
    tbl[5]  = row(0, 0, 1, 0, 4'h2, DN);
    tbl[6]  = row(0, 1, 1, 0, 4'h2, DN);
    tbl[7]  = row(1, 0, 1, 0, 4'h2, DN);
    tbl[8]  = row(0, 0, 1, 0, 4'h7, FREQ | ILD);
    tbl[9]  = row(1, 0, 1, 0, 4'h7, 15'h0);
    tbl[10] = row(0, 0, 1, 0, 4'h7, BR | PC | A3);
    tbl[11] = row(0, 0, 1, 0, 4'h7, FREQ | ILD);
    tbl[12] = row(0, 0, 1, 0, 4'h7, 15'h0);
    tbl[13] = row(0, 1, 1, 0, 4'h7, BR | PC | A3);
    tbl[14] = row(0, 0, 1, 0, 4'h7, DN);
    n = 15;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      {Start, Halt, FetchAck, MemAck, op4} = tbl[i][22:15];
      #1;
      checks++;
      if (ob0 !== tbl[i][14:0]) begin
        fails++; $display("FAIL halt step %0d: got %h want %h", i, ob0, tbl[i][14:0]);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    tbl[0] = row(1, 0, 1, 0, 4'h0, 15'h0);
    tbl[1] = row(0, 0, 1, 0, 4'h0, FREQ | ILD);
    tbl[2] = row(0, 0, 1, 0, 4'hA, 15'h0);
    tbl[3] = row(0, 0, 1, 0, 4'hA, DN | IL);
    tbl[4] = row(0, 0, 1, 0, 4'hA, DN | IL);
    tbl[5] = row(1, 0, 0, 0, 4'hA, DN | IL);
    tbl[6] = row(0, 0, 1, 0, 4'h2, FREQ | ILD);
    tbl[7] = row(0, 0, 1, 0, 4'h2, 15'h0);
    tbl[8] = row(0, 0, 1, 0, 4'h2, A1);
    n = 9;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      {Start, Halt, FetchAck, MemAck, op4} = tbl[i][22:15];
      #1;
      checks++;
      if (ob1 !== tbl[i][14:0]) begin
        fails++; $display("FAIL illegal step %0d: got %h want %h", i, ob1, tbl[i][14:0]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tbl[0]  = row(1, 0, 0, 0, 4'h1, 15'h0);
    tbl[1]  = row(0, 0, 0, 0, 4'h1, FREQ);
    tbl[2]  = row(0, 0, 0, 0, 4'h1, FREQ);
    tbl[3]  = row(0, 0, 0, 0, 4'h1, FREQ);
    tbl[4]  = row(0, 0, 0, 0, 4'h1, FREQ);
    tbl[5]  = row(0, 0, 0, 0, 4'h1, FREQ);
    tbl[6]  = row(0, 0, 0, 0, 4'h1, DN | TO);
    tbl[7]  = row(1, 0, 0, 0, 4'h1, DN | TO);
    tbl[8]  = row(0, 0, 0, 0, 4'h1, FREQ);
    tbl[9]  = row(0, 0, 0, 0, 4'h1, FREQ);
    tbl[10] = row(0, 0, 0, 0, 4'h1, FREQ);
    tbl[11] = row(0, 0, 0, 0, 4'h1, FREQ);
    tbl[12] = row(0, 0, 1, 0, 4'h1, FREQ | ILD);
    tbl[13] = row(0, 0, 0, 0, 4'h1, 15'h0);
    tbl[14] = row(0, 0, 0, 0, 4'h1, LD);
    tbl[15] = row(0, 0, 0, 0, 4'h1, LD | RM);
    tbl[16] = row(0, 0, 0, 0, 4'h1, LD | RM);
    tbl[17] = row(0, 0, 0, 0, 4'h1, LD | RM);
    tbl[18] = row(0, 0, 0, 0, 4'h1, LD | RM);
    tbl[19] = row(0, 0, 0, 0, 4'h1, LD | RM);
    tbl[20] = row(0, 0, 0, 0, 4'h1, DN | TO);
    n = 21;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      {Start, Halt, FetchAck, MemAck, op4} = tbl[i][22:15];
      #1;
      checks++;
      if (ob2 !== tbl[i][14:0]) begin
        fails++; $display("FAIL timeout step %0d: got %h want %h", i, ob2, tbl[i][14:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Opcode 1001: lb for the 3-bit instances, illegal for the OPW=4 instance.
    tbl[0] = row(1, 0, 1, 0, 4'h9, 15'h0);
    tbl[1] = row(0, 0, 1, 0, 4'h9, FREQ | ILD);
    tbl[2] = row(0, 0, 0, 0, 4'h9, 15'h0);
    tbl[3] = row(0, 0, 0, 0, 4'h9, LD);
    tbl[4] = row(0, 0, 0, 0, 4'h9, LD | RM);
    n = 5;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      {Start, Halt, FetchAck, MemAck, op4} = tbl[i][22:15];
      #1;
      checks++;
      if (ob0 !== tbl[i][14:0]) begin
        fails++; $display("FAIL reset_mid step %0d: got %h want %h", i, ob0, tbl[i][14:0]);
      end
    end
    checks++;
    if (ob1 !== (DN | IL)) begin fails++; $display("FAIL reset_mid pre dut1: got %h want %h", ob1, DN | IL); end
    #1 Reset_n = 1'b0;
    #1;
    checks++;
    if (ob0 !== 15'h0) begin fails++; $display("FAIL reset_mid dut0: got %h want %h", ob0, 15'h0); end
    checks++;
    if (ob1 !== 15'h0) begin fails++; $display("FAIL reset_mid dut1: got %h want %h", ob1, 15'h0); end
    checks++;
    if (ob2 !== 15'h0) begin fails++; $display("FAIL reset_mid dut2: got %h want %h", ob2, 15'h0); end
    @(negedge CLK);
    {Start, Halt, FetchAck, MemAck, op4} = '0;
    Reset_n = 1'b1;
    @(negedge CLK);
    #1;
    checks++;
    if (ob0 !== 15'h0) begin fails++; $display("FAIL reset_mid idle: got %h want %h", ob0, 15'h0); end
  endtask

`ifdef CTRL_PERF_EN
  task automatic test_perf();
    do_reset();
    tbl[0] = row(1, 0, 1, 0, 4'h2, 15'h0);
    for (int k = 0; k < 3; k++) begin
      tbl[1 + 4 * k] = row(0, 0, 1, 0, 4'h2, FREQ | ILD);
      tbl[2 + 4 * k] = row(0, 0, 1, 0, 4'h2, 15'h0);
      tbl[3 + 4 * k] = row(0, 0, 1, 0, 4'h2, A1);
      tbl[4 + 4 * k] = row(0, 0, 1, 0, 4'h2, A1 | WR | PC);
    end
    n = 13;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      {Start, Halt, FetchAck, MemAck, op4} = tbl[i][22:15];
      #1;
      checks++;
      if (ob0 !== tbl[i][14:0]) begin
        fails++; $display("FAIL perf step %0d: got %h want %h", i, ob0, tbl[i][14:0]);
      end
    end
    @(negedge CLK);
    FetchAck = 1'b0;
    #1;
    checks++;
    if (ic0 !== 32'd3) begin fails++; $display("FAIL perf instr_count: got %0d want %0d", ic0, 3); end
    checks++;
    if (sc0 !== 32'd0) begin fails++; $display("FAIL perf stall_count0: got %0d want %0d", sc0, 0); end
    @(negedge CLK);
    #1;
    checks++;
    if (sc0 !== 32'd1) begin fails++; $display("FAIL perf stall_count1: got %0d want %0d", sc0, 1); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_ops();
    test_load();
    test_branch_store();
    test_halt();
    test_illegal();
    test_timeout();
    test_reset_mid();
`ifdef CTRL_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
